fetch_unit: RTL

Instruction fetch stage sitting directly upstream of decode/execute and driving the 16-entry combinational program ROM. Holds the program counter, presents it as the ROM address, and latches the returned 16-bit word into an instruction register (IR) with a valid flag. Supports pipeline stall and control-flow redirect from execute. Optionally resolves unconditional `jmp` locally.

---
 rtl/fetch_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of decode/execute.
// Holds the PC, drives the combinational ROM address, and registers the
// returned word into IR with a valid flag. Handles stall and redirect.
// Optional feature macro: FETCH_LOCAL_JMP_EN. When it is defined, an
// unconditional jmp (opcode 4'b1000) is resolved here without a bubble.
module fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic [7:0]        fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [INST_W-1:0]   ir_nxt;
    logic [ADDR_W-1:0]   ir_pc_nxt;
    logic                ir_valid_nxt;
    logic [7:0]          fetch_cnt_nxt;

    // State and datapath registers; every output is a flop, so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pc_addr   <= '0;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pc_addr   <= pc_nxt;
            ir        <= ir_nxt;
            ir_pc     <= ir_pc_nxt;
            ir_valid  <= ir_valid_nxt;
            fetch_cnt <= fetch_cnt_nxt;
        end
    end

    // Next-state logic: redirect beats stall, stall beats fetch; all states fetch the same way.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_addr;
        ir_nxt        = ir;
        ir_pc_nxt     = ir_pc;
        ir_valid_nxt  = ir_valid;
        fetch_cnt_nxt = fetch_cnt;

        if (redirect) begin
            // Bubble: squash IR, keep ir_pc and the load count.
            pc_nxt       = redirect_addr;
            ir_nxt       = '0;
            ir_valid_nxt = 1'b0;
            state_nxt    = FLUSH;
        end else if (!stall) begin
            ir_nxt        = rom_inst;
            ir_pc_nxt     = pc_addr;
            ir_valid_nxt  = 1'b1;
            fetch_cnt_nxt = fetch_cnt + 8'd1;
            state_nxt     = RUN;
            pc_nxt        = pc_addr + ADDR_W'(1);
`ifdef FETCH_LOCAL_JMP_EN
            // jmp target comes straight from the word being loaded, so no bubble.
            if (rom_inst[15:12] == 4'b1000) begin
                pc_nxt = ADDR_W'(rom_inst[11:8]);
            end
`endif
        end
    end

endmodule
